zint_ctrl: RTL and testbench



---
 rtl/zint_ctrl_if.sv | 34 +++
 rtl/zint_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_zint_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/zint_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : zint_ctrl_if
// Description : Bus bundle for the ZX INT controller. It carries the raw
//               interrupt inputs, the register write/read port and the two
//               request outputs.
//               master : drives src, wr_stb, addr, wrdata;
//                        observes rddata, int_oe, irq
//               slave  : the controller itself
// Revision    : 1.0 - initial release
// ============================================================================
interface zint_ctrl_if #(
    parameter int NSRC = 4
);
    logic [NSRC-1:0] src;      // raw interrupt inputs, active-high, async
    logic            wr_stb;   // single-cycle register write strobe
    logic [1:0]      addr;     // register address
    logic [7:0]      wrdata;   // write data
    logic [7:0]      rddata;   // read data, combinational from addr
    logic            int_oe;   // drive ZX INT low when 1
    logic            irq;      // registered internal request

    modport master (
        output src, wr_stb, addr, wrdata,
        input  rddata, int_oe, irq
    );

    modport slave (
        input  src, wr_stb, addr, wrdata,
        output rddata, int_oe, irq
    );
endinterface
`default_nettype wire

// File: rtl/zint_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : zint_ctrl
// Description : NSRC-source interrupt controller for the ZX-bus card.
//               Each source is synchronised, latched as level or rising edge
//               into a pending register, masked by a per-source enable and a
//               global enable, and turned into a fixed-width open-drain INT
//               pulse with a guaranteed re-arm gap.
// Ports       : clk  - system clock
//               rst  - synchronous active-high reset
//               bus  - zint_ctrl_if.slave (src, wr_stb, addr, wrdata in;
//                      rddata, int_oe, irq out)
// Registers   : 0 ENA  1 MODE  2 PEND (W1C, edge bits only)
//               3 CTRL {irq, int_oe, GENA, 2'b0, vec[2:0]}
// Revision    : 1.0 - initial release
// ============================================================================
module zint_ctrl #(
    parameter int NSRC      = 4,
    parameter int PULSE_LEN = 32,
    parameter int GAP_LEN   = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    zint_ctrl_if.slave     bus
);

    // Counter only ever holds load values (LEN-1), so log2(max) bits suffice.
    localparam int c_CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int c_CNT_W   = (c_CNT_MAX > 2) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_PULSE_LOAD = c_CNT_W'(PULSE_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD   = c_CNT_W'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [NSRC-1:0]    r_s1;
    logic [NSRC-1:0]    r_s2;
    logic [NSRC-1:0]    r_s3;
    logic [NSRC-1:0]    r_ena;
    logic [NSRC-1:0]    r_mode;
    logic [NSRC-1:0]    r_pend;
    logic               r_gena;
    logic               r_irq;
    logic               r_int_oe;
    logic [c_CNT_W-1:0] r_cnt;
    state_t             r_state;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic [NSRC-1:0] w_edge;
    logic [NSRC-1:0] w_wdat;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_mode_chg;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_act;
    logic            w_wr_ena;
    logic            w_wr_mode;
    logic            w_wr_pend;
    logic            w_wr_ctrl;
    logic            w_req;
    logic [2:0]      w_vec;
    logic [7:0]      w_rd;
    logic            w_unused_wrdata;

    // Bits of wrdata above NSRC are architecturally ignored.
    assign w_unused_wrdata = ^bus.wrdata;

    assign w_edge    = r_s2 & ~r_s3;
    assign w_wdat    = bus.wrdata[NSRC-1:0];
    assign w_wr_ena  = bus.wr_stb && (bus.addr == 2'd0);
    assign w_wr_mode = bus.wr_stb && (bus.addr == 2'd1);
    assign w_wr_pend = bus.wr_stb && (bus.addr == 2'd2);
    assign w_wr_ctrl = bus.wr_stb && (bus.addr == 2'd3);

    assign w_clr      = w_wr_pend ? w_wdat : '0;
    // A mode flip discards whatever was latched under the old interpretation.
    assign w_mode_chg = w_wr_mode ? (w_wdat ^ r_mode) : '0;

    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_mode_chg[i]) begin
                w_pend_nxt[i] = 1'b0;
            end else if (r_mode[i]) begin
                // Set has priority over a same-cycle W1C.
                w_pend_nxt[i] = w_edge[i] | (r_pend[i] & ~w_clr[i]);
            end else begin
                w_pend_nxt[i] = r_s2[i];
            end
        end
    end

    assign w_act = r_pend & r_ena;
    assign w_req = r_gena & (|w_act);

    // Lowest active index wins; scan downward so the last hit is the lowest.
    always_comb begin
        w_vec = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_act[i]) begin
                w_vec = 3'(i);
            end
        end
    end

    always_comb begin
        w_rd = '0;
        case (bus.addr)
            2'd0: w_rd[NSRC-1:0] = r_ena;
            2'd1: w_rd[NSRC-1:0] = r_mode;
            2'd2: w_rd[NSRC-1:0] = r_pend;
            2'd3: w_rd = {r_irq, r_int_oe, r_gena, 2'b00, w_vec};
        endcase
    end

    assign bus.rddata = w_rd;
    assign bus.int_oe = r_int_oe;
    assign bus.irq    = r_irq;

    // ------------------------------------------------------------------------
    // Synchroniser, registers and pending latches
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_ena  <= '0;
            r_mode <= '0;
            r_pend <= '0;
            r_gena <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_s1   <= bus.src;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_pend <= w_pend_nxt;
            r_irq  <= w_req;
            if (w_wr_ena) begin
                r_ena <= w_wdat;
            end
            if (w_wr_mode) begin
                r_mode <= w_wdat;
            end
            if (w_wr_ctrl) begin
                r_gena <= bus.wrdata[0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // INT pulse shaper: once started a pulse always runs its full length,
    // followed by a mandatory gap before the next one may begin.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_int_oe <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state  <= ST_PULSE;
                        r_int_oe <= 1'b1;
                        r_cnt    <= c_PULSE_LOAD;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state  <= ST_GAP;
                        r_int_oe <= 1'b0;
                        r_cnt    <= c_GAP_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_int_oe <= 1'b0;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zint_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_zint_ctrl
// Description : Scoreboard bench for zint_ctrl. Stimulus pushes expected
//               values tagged with the cycle they must appear on; a monitor
//               samples on the falling edge and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zint_ctrl;

    localparam int NSRC      = 4;
    localparam int PULSE_LEN = 32;
    localparam int GAP_LEN   = 8;

    localparam int K_RD  = 0;
    localparam int K_OE  = 1;
    localparam int K_IRQ = 2;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] exp;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    zint_ctrl_if #(.NSRC(NSRC)) bus ();

    zint_ctrl #(
        .NSRC      (NSRC),
        .PULSE_LEN (PULSE_LEN),
        .GAP_LEN   (GAP_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Ordered insert so expectations can be queued for future cycles.
    task automatic push(input int c, input int k, input logic [7:0] e, input string nm);
        exp_t it;
        int   i;
        it.cyc  = c;
        it.kind = k;
        it.exp  = e;
        it.name = nm;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, it);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.wr_stb = 1'b1;
        bus.addr   = a;
        bus.wrdata = d;
        tick();
        bus.wr_stb = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Monitor / checker
    // ------------------------------------------------------------------------
    exp_t       mon_it;
    logic [7:0] mon_act;

    initial begin
        while (!done) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mon_it = sb.pop_front();
                n_checks++;
                case (mon_it.kind)
                    K_RD:    mon_act = bus.rddata;
                    K_OE:    mon_act = {7'd0, bus.int_oe};
                    default: mon_act = {7'd0, bus.irq};
                endcase
                if (mon_it.cyc < cyc) begin
                    n_fail++;
                    $display("FAIL %s: sample for cycle %0d missed (now %0d)",
                             mon_it.name, mon_it.cyc, cyc);
                end else if (mon_act !== mon_it.exp) begin
                    n_fail++;
                    $display("FAIL %s: cycle %0d got 0x%02h expected 0x%02h",
                             mon_it.name, cyc, mon_act, mon_it.exp);
                end
            end
        end
        while (sb.size() > 0) begin
            mon_it = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never sampled, expected 0x%02h at cycle %0d",
                     mon_it.name, mon_it.exp, mon_it.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int c0;
        int c2;
        bus.src    = '0;
        bus.wr_stb = 1'b0;
        bus.addr   = 2'd0;
        bus.wrdata = 8'h00;
        rst        = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset then idle
        push(cyc, K_OE, 8'h00, "rst_int_oe");
        push(cyc, K_IRQ, 8'h00, "rst_irq");
        for (int a = 0; a < 4; a++) begin
            bus.addr = 2'(a);
            push(cyc, K_RD, 8'h00, "rst_reg");
            tick();
        end

        // Level source 0: k+3 response, 32 high, gap, re-arm
        wr(2'd0, 8'h01);
        wr(2'd1, 8'h00);
        wr(2'd3, 8'h01);
        c0 = cyc;
        bus.src  = 4'b0001;
        bus.addr = 2'd2;
        push(c0 + 2, K_RD, 8'h00, "lvl_pend_pre");
        push(c0 + 3, K_RD, 8'h01, "lvl_pend_set");
        push(c0 + 3, K_IRQ, 8'h00, "lvl_irq_pre");
        push(c0 + 3, K_OE, 8'h00, "lvl_oe_pre");
        push(c0 + 4, K_IRQ, 8'h01, "lvl_irq_set");
        for (int i = 0; i < PULSE_LEN; i++) push(c0 + 4 + i, K_OE, 8'h01, "lvl_pulse_hi");
        for (int i = 0; i <= GAP_LEN; i++) push(c0 + 4 + PULSE_LEN + i, K_OE, 8'h00, "lvl_gap_lo");
        for (int i = 0; i < 3; i++) push(c0 + 5 + PULSE_LEN + GAP_LEN + i, K_OE, 8'h01, "lvl_rearm");
        wait_until(c0 + 10);
        bus.addr = 2'd3;
        push(c0 + 10, K_RD, 8'hE0, "lvl_ctrl");
        wait_until(c0 + 48);
        bus.src = '0;
        push(c0 + 90, K_OE, 8'h00, "lvl_release_oe");
        push(c0 + 90, K_IRQ, 8'h00, "lvl_release_irq");
        wait_until(c0 + 95);

        // Edge source 2: latch, vec, W1C, edge-vs-W1C race
        wr(2'd0, 8'h04);
        wr(2'd1, 8'h04);
        c0 = cyc;
        bus.src = 4'b0100;
        tick();
        bus.src  = '0;
        bus.addr = 2'd2;
        push(c0 + 2, K_RD, 8'h00, "edg_pend_pre");
        push(c0 + 3, K_RD, 8'h04, "edg_pend_set");
        push(c0 + 5, K_RD, 8'h04, "edg_pend_hold");
        wait_until(c0 + 6);
        bus.addr = 2'd3;
        push(c0 + 6, K_RD, 8'hE2, "edg_ctrl_vec2");
        wait_until(c0 + 7);
        push(c0 + 8, K_RD, 8'h00, "edg_w1c_pend");
        push(c0 + 8, K_IRQ, 8'h01, "edg_w1c_irq_prev");
        push(c0 + 9, K_IRQ, 8'h00, "edg_w1c_irq");
        wr(2'd2, 8'h04);
        c2 = cyc;
        bus.src = 4'b0100;
        tick();
        bus.src = '0;
        tick();
        push(c2 + 3, K_RD, 8'h04, "edg_race_set");
        push(c2 + 4, K_RD, 8'h04, "edg_race_hold");
        wr(2'd2, 8'h04);
        tick();
        push(cyc + 1, K_RD, 8'h00, "edg_final_clr");
        wr(2'd2, 8'h04);
        wait_until(cyc + 60);

        // Priority / masking with global disable mid-pulse
        wr(2'd1, 8'h00);
        wr(2'd0, 8'h08);
        c0 = cyc;
        bus.src  = 4'b1010;
        bus.addr = 2'd3;
        push(c0 + 5, K_RD, 8'hE3, "pri_vec3");
        wait_until(c0 + 6);
        wr(2'd0, 8'h0A);
        bus.addr = 2'd3;
        push(c0 + 7, K_RD, 8'hE1, "pri_vec1");
        wait_until(c0 + 10);
        wr(2'd3, 8'h00);
        bus.addr = 2'd3;
        push(c0 + 11, K_RD, 8'hC1, "pri_gena_off");
        push(c0 + 12, K_RD, 8'h41, "pri_irq_drop");
        push(c0 + 12, K_IRQ, 8'h00, "pri_irq");
        push(c0 + 35, K_OE, 8'h01, "pri_pulse_tail");
        for (int i = 36; i <= 60; i++) push(c0 + i, K_OE, 8'h00, "pri_oe_quiet");
        wait_until(c0 + 62);

        // Minimum width: one-cycle level blip still gives a full pulse
        bus.src = '0;
        wait_until(cyc + 5);
        wr(2'd0, 8'h01);
        wr(2'd3, 8'h01);
        c0 = cyc;
        bus.src = 4'b0001;
        tick();
        bus.src = '0;
        push(c0 + 3, K_OE, 8'h00, "min_oe_pre");
        push(c0 + 4, K_IRQ, 8'h01, "min_irq_hi");
        push(c0 + 5, K_IRQ, 8'h00, "min_irq_lo");
        for (int i = 0; i < PULSE_LEN; i++) push(c0 + 4 + i, K_OE, 8'h01, "min_pulse_hi");
        for (int i = 36; i <= 50; i++) push(c0 + i, K_OE, 8'h00, "min_after");
        wait_until(c0 + 52);

        // Reset at pulse cycle 10
        c0 = cyc;
        bus.src = 4'b0001;
        push(c0 + 13, K_OE, 8'h01, "rstp_oe_before");
        push(c0 + 14, K_OE, 8'h00, "rstp_oe_drop");
        push(c0 + 14, K_IRQ, 8'h00, "rstp_irq_drop");
        wait_until(c0 + 13);
        rst = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus.addr = 2'(a);
            push(c0 + 14 + a, K_RD, 8'h00, "rstp_reg");
            tick();
        end
        rst     = 1'b0;
        bus.src = '0;
        wait_until(cyc + 5);
        done = 1'b1;
    end

endmodule
`default_nettype wire
